morse_receiver: RTL and testbench



---
 rtl/morse_receiver_pkg.sv | 23 ++
 rtl/morse_lut.sv | 58 +++++
 rtl/morse_receiver.sv | 237 +++++++++++++++++++++++
 tb/tb_morse_receiver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/morse_receiver_pkg.sv
// Shared definitions for the Morse receiver: FSM states, timing thresholds
// in eighth-unit ticks, and the word-gap character.
package morse_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MARK      = 3'd1,
        ST_SPACE     = 3'd2,
        ST_WAIT_WORD = 3'd3,
        ST_STUCK     = 3'd4
    } state_e;

    localparam logic [6:0] GLITCH_T = 7'd2;
    localparam logic [6:0] DASH_T   = 7'd16;
    localparam logic [6:0] LETTER_T = 7'd16;
    localparam logic [6:0] WORD_T   = 7'd40;
    localparam logic [6:0] STUCK_T  = 7'd64;
    localparam logic [6:0] DUR_MAX  = 7'd127;

    localparam logic [2:0] MAX_LEN     = 3'd6;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse pattern to ASCII decoder. The first element keyed sits
// at bit LEN-1 of PAT (dot = 0, dash = 1); unused upper bits are zero.
module morse_lut (
    input  logic [2:0] LEN,
    input  logic [5:0] PAT,
    output logic [7:0] ASCII,
    output logic       HIT
);

    // Table lookup over the full {LEN, PAT} key
    always_comb begin
        ASCII = 8'h00;
        HIT   = 1'b1;
        case ({LEN, PAT})
            {3'd2, 6'b000001}: ASCII = 8'h41; // A
            {3'd4, 6'b001000}: ASCII = 8'h42;
            {3'd4, 6'b001010}: ASCII = 8'h43;
            {3'd3, 6'b000100}: ASCII = 8'h44;
            {3'd1, 6'b000000}: ASCII = 8'h45;
            {3'd4, 6'b000010}: ASCII = 8'h46;
            {3'd3, 6'b000110}: ASCII = 8'h47;
            {3'd4, 6'b000000}: ASCII = 8'h48;
            {3'd2, 6'b000000}: ASCII = 8'h49;
            {3'd4, 6'b000111}: ASCII = 8'h4A;
            {3'd3, 6'b000101}: ASCII = 8'h4B;
            {3'd4, 6'b000100}: ASCII = 8'h4C;
            {3'd2, 6'b000011}: ASCII = 8'h4D;
            {3'd2, 6'b000010}: ASCII = 8'h4E;
            {3'd3, 6'b000111}: ASCII = 8'h4F;
            {3'd4, 6'b000110}: ASCII = 8'h50;
            {3'd4, 6'b001101}: ASCII = 8'h51;
            {3'd3, 6'b000010}: ASCII = 8'h52;
            {3'd3, 6'b000000}: ASCII = 8'h53;
            {3'd1, 6'b000001}: ASCII = 8'h54;
            {3'd3, 6'b000001}: ASCII = 8'h55;
            {3'd4, 6'b000001}: ASCII = 8'h56;
            {3'd3, 6'b000011}: ASCII = 8'h57;
            {3'd4, 6'b001001}: ASCII = 8'h58;
            {3'd4, 6'b001011}: ASCII = 8'h59;
            {3'd4, 6'b001100}: ASCII = 8'h5A; // Z
            {3'd5, 6'b011111}: ASCII = 8'h30; // 0
            {3'd5, 6'b001111}: ASCII = 8'h31;
            {3'd5, 6'b000111}: ASCII = 8'h32;
            {3'd5, 6'b000011}: ASCII = 8'h33;
            {3'd5, 6'b000001}: ASCII = 8'h34;
            {3'd5, 6'b000000}: ASCII = 8'h35;
            {3'd5, 6'b010000}: ASCII = 8'h36;
            {3'd5, 6'b011000}: ASCII = 8'h37;
            {3'd5, 6'b011100}: ASCII = 8'h38;
            {3'd5, 6'b011110}: ASCII = 8'h39; // 9
            default: begin
                ASCII = 8'h00;
                HIT   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/morse_receiver.sv
// Morse receiver: synchronizes the keyed line, times marks and spaces in
// eighth-unit ticks, classifies elements and emits decoded ASCII characters.
module morse_receiver
    import morse_receiver_pkg::*;
#(
    parameter  int UNIT_CYCLES = 5000000,
    localparam int SUB_CYCLES  = UNIT_CYCLES / 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       MORSE_IN,
    output logic [7:0] CHAR,
    output logic       CHAR_VALID,
    output logic       ERR,
    output logic       BUSY
);

    localparam int SUB_W = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_CYCLES - 1);

    logic             sync1_q, sync2_q, level_q;
    logic [SUB_W-1:0] sub_q;
    state_e           state_q, state_d;
    logic [6:0]       dur_q, dur_d;
    logic [5:0]       pat_q, pat_d;
    logic [2:0]       len_q, len_d;
    logic             ovf_q, ovf_d;
    state_e           sv_state_q, sv_state_d;
    logic [6:0]       sv_dur_q, sv_dur_d;
    logic [6:0]       mk_dur_q, mk_dur_d;
    logic [5:0]       mk_pat_q, mk_pat_d;
    logic [2:0]       mk_len_q, mk_len_d;
    logic             mk_ovf_q, mk_ovf_d;
    logic             emitted_q, emitted_d;
    logic [7:0]       char_q, char_d;
    logic             cv_q, cv_d;
    logic             err_q, err_d;
    logic             busy_q;

    logic             rise_s, fall_s, edge_s, tick_s;
    logic [6:0]       dur_tick_s;
    logic [7:0]       lut_ascii_s;
    logic             lut_hit_s;

    assign rise_s     = sync2_q & ~level_q;
    assign fall_s     = ~sync2_q & level_q;
    assign edge_s     = rise_s | fall_s;
    // An edge restarts the tick counter, so a coincident tick never fires.
    assign tick_s     = (sub_q == SUB_LAST) & ~edge_s;
    assign dur_tick_s = (dur_q == DUR_MAX) ? dur_q : dur_q + 7'd1;

    morse_lut u_lut (
        .LEN   (len_q),
        .PAT   (pat_q),
        .ASCII (lut_ascii_s),
        .HIT   (lut_hit_s)
    );

    // Input synchronizer, edge-detect delay and edge-aligned tick counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            sub_q   <= '0;
        end else begin
            sync1_q <= MORSE_IN;
            sync2_q <= sync1_q;
            level_q <= sync2_q;
            sub_q   <= (edge_s || sub_q == SUB_LAST) ? '0 : sub_q + SUB_W'(1);
        end
    end

    // State, duration, element buffer and glitch-undo snapshots
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            dur_q      <= 7'd0;
            pat_q      <= 6'd0;
            len_q      <= 3'd0;
            ovf_q      <= 1'b0;
            sv_state_q <= ST_IDLE;
            sv_dur_q   <= 7'd0;
            mk_dur_q   <= 7'd0;
            mk_pat_q   <= 6'd0;
            mk_len_q   <= 3'd0;
            mk_ovf_q   <= 1'b0;
            emitted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dur_q      <= dur_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            sv_state_q <= sv_state_d;
            sv_dur_q   <= sv_dur_d;
            mk_dur_q   <= mk_dur_d;
            mk_pat_q   <= mk_pat_d;
            mk_len_q   <= mk_len_d;
            mk_ovf_q   <= mk_ovf_d;
            emitted_q  <= emitted_d;
        end
    end

    // Next-state logic; edges are tested before threshold ticks
    always_comb begin
        state_d    = state_q;
        dur_d      = tick_s ? dur_tick_s : dur_q;
        pat_d      = pat_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        sv_state_d = sv_state_q;
        sv_dur_d   = sv_dur_q;
        mk_dur_d   = mk_dur_q;
        mk_pat_d   = mk_pat_q;
        mk_len_d   = mk_len_q;
        mk_ovf_d   = mk_ovf_q;
        emitted_d  = emitted_q;
        char_d     = char_q;
        cv_d       = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE, ST_WAIT_WORD: begin
                if (rise_s) begin
                    sv_state_d = state_q;
                    sv_dur_d   = dur_q;
                    state_d    = ST_MARK;
                    dur_d      = 7'd0;
                end else if (state_q == ST_WAIT_WORD && tick_s && dur_q == WORD_T - 7'd1) begin
                    if (emitted_q) begin
                        char_d = ASCII_SPACE;
                        cv_d   = 1'b1;
                    end else begin
                        char_d = char_q;
                    end
                    emitted_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_MARK: begin
                if (fall_s) begin
                    if (dur_q < GLITCH_T) begin
                        state_d = sv_state_q;
                        dur_d   = sv_dur_q;
                    end else begin
                        // Snapshot lets a following one-cycle space be undone.
                        mk_dur_d = dur_q;
                        mk_pat_d = pat_q;
                        mk_len_d = len_q;
                        mk_ovf_d = ovf_q;
                        if (len_q == MAX_LEN) begin
                            ovf_d = 1'b1;
                        end else begin
                            pat_d = {pat_q[4:0], (dur_q >= DASH_T)};
                            len_d = len_q + 3'd1;
                            ovf_d = ovf_q | (len_q == MAX_LEN - 3'd1);
                        end
                        state_d = ST_SPACE;
                        dur_d   = 7'd0;
                    end
                end else if (tick_s && dur_q == STUCK_T - 7'd1) begin
                    err_d     = 1'b1;
                    emitted_d = 1'b1;
                    pat_d     = 6'd0;
                    len_d     = 3'd0;
                    ovf_d     = 1'b0;
                    state_d   = ST_STUCK;
                    dur_d     = 7'd0;
                end else begin
                    state_d = ST_MARK;
                end
            end
            ST_SPACE: begin
                if (rise_s) begin
                    if (dur_q < GLITCH_T) begin
                        pat_d = mk_pat_q;
                        len_d = mk_len_q;
                        ovf_d = mk_ovf_q;
                        dur_d = mk_dur_q;
                    end else begin
                        sv_state_d = ST_SPACE;
                        sv_dur_d   = dur_q;
                        dur_d      = 7'd0;
                    end
                    state_d = ST_MARK;
                end else if (tick_s && dur_q == LETTER_T - 7'd1) begin
                    if (lut_hit_s && !ovf_q) begin
                        char_d = lut_ascii_s;
                        cv_d   = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                    emitted_d = 1'b1;
                    pat_d     = 6'd0;
                    len_d     = 3'd0;
                    ovf_d     = 1'b0;
                    state_d   = ST_WAIT_WORD;
                end else begin
                    state_d = ST_SPACE;
                end
            end
            ST_STUCK: begin
                if (fall_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STUCK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            char_q <= 8'h00;
            cv_q   <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            char_q <= char_d;
            cv_q   <= cv_d;
            err_q  <= err_d;
            busy_q <= (state_d != ST_IDLE);
        end
    end

    assign CHAR       = char_q;
    assign CHAR_VALID = cv_q;
    assign ERR        = err_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_morse_receiver.sv
// Randomized scoreboard bench for morse_receiver (UNIT_CYCLES = 16, so one
// eighth-unit is two clocks). Expected characters come from a dot/dash table.
module tb_morse_receiver;

    localparam int UNIT = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic       MORSE_IN;
    logic [7:0] CHAR;
    logic       CHAR_VALID;
    logic       ERR;
    logic       BUSY;

    typedef struct packed {
        logic       is_err;
        logic [7:0] ch;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_char;
    bit         emitted;

    string codes[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                         "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                         "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                         "-.--", "--..", "-----", ".----", "..---", "...--",
                         "....-", ".....", "-....", "--...", "---..", "----."};
    string bad_codes[4] = '{"..--", "......", "----", ".-.-.-"};

    morse_receiver #(.UNIT_CYCLES(UNIT)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .MORSE_IN   (MORSE_IN),
        .CHAR       (CHAR),
        .CHAR_VALID (CHAR_VALID),
        .ERR        (ERR),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic void lookup(input string s, output bit hit, output logic [7:0] a);
        hit = 1'b0;
        a   = 8'h00;
        for (int i = 0; i < 36; i++) begin
            if (codes[i] == s) begin
                hit = 1'b1;
                a   = (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
            end
        end
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int cyc);
        MORSE_IN = lvl;
        repeat (cyc) @(negedge CLK);
    endtask

    task automatic eighths(input logic lvl, input int n);
        drive(lvl, 2 * n);
    endtask

    // A dot is under 2 units, a dash at least 2; gaps inside a letter under 2.
    task automatic key_elems(input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "-") eighths(1'b1, int'($urandom_range(29, 19)));
            else             eighths(1'b1, int'($urandom_range(11, 5)));
            if (i < s.len() - 1) eighths(1'b0, int'($urandom_range(11, 5)));
        end
    endtask

    task automatic expect_letter(input string s);
        bit         hit;
        logic [7:0] a;
        lookup(s, hit, a);
        if (hit) begin
            sb_q.push_back('{1'b0, a});
            last_char = a;
        end else begin
            sb_q.push_back('{1'b1, last_char});
        end
        emitted = 1'b1;
    endtask

    task automatic expect_space();
        if (emitted) begin
            sb_q.push_back('{1'b0, 8'h20});
            last_char = 8'h20;
        end
        emitted = 1'b0;
    endtask

    task automatic key_word(input string letters[$]);
        for (int i = 0; i < letters.size(); i++) begin
            key_elems(letters[i]);
            expect_letter(letters[i]);
            if (i < letters.size() - 1) begin
                eighths(1'b0, int'($urandom_range(32, 20)));
            end else begin
                expect_space();
                eighths(1'b0, int'($urandom_range(72, 56)));
            end
        end
        check("busy_after_word", {7'd0, BUSY}, 8'h00);
    endtask

    // Scoreboard monitor: every output pulse must match the next expectation
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && (CHAR_VALID || ERR)) begin
            checks++;
            if (CHAR_VALID && ERR) begin
                errors++;
                $display("FAIL both_pulses: CHAR_VALID and ERR together, CHAR=%02h", CHAR);
            end else if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: valid=%0b err=%0b CHAR=%02h", CHAR_VALID, ERR, CHAR);
            end else begin
                e = sb_q.pop_front();
                if (ERR !== e.is_err || CHAR !== e.ch) begin
                    errors++;
                    $display("FAIL decode: got err=%0b CHAR=%02h expected err=%0b CHAR=%02h",
                             ERR, CHAR, e.is_err, e.ch);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: stimulus did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        string w[$];
        int    n;
        RST       = 1'b1;
        MORSE_IN  = 1'b0;
        last_char = 8'h00;
        emitted   = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst_char", CHAR, 8'h00);
        check("rst_valid", {7'd0, CHAR_VALID}, 8'h00);
        check("rst_err", {7'd0, ERR}, 8'h00);
        check("rst_busy", {7'd0, BUSY}, 8'h00);
        RST = 1'b0;
        eighths(1'b0, 20);
        check("idle_busy", {7'd0, BUSY}, 8'h00);

        // 'A' with BUSY observed inside the word gap
        key_elems(".-");
        expect_letter(".-");
        expect_space();
        eighths(1'b0, 24);
        check("busy_wait_word", {7'd0, BUSY}, 8'h01);
        check("char_a", CHAR, 8'h41);
        eighths(1'b0, 40);
        check("busy_after_a", {7'd0, BUSY}, 8'h00);

        w = '{"...", "---", "..."};
        key_word(w);
        w = '{"-----", "......"};
        key_word(w);

        // 'T' with a one-clock drop mid-dash and a one-clock mark in the gap
        eighths(1'b1, 12);
        drive(1'b0, 1);
        eighths(1'b1, 12);
        expect_letter("-");
        eighths(1'b0, 10);
        drive(1'b1, 1);
        expect_space();
        eighths(1'b0, 60);
        check("char_t", CHAR, 8'h20);
        check("busy_after_t", {7'd0, BUSY}, 8'h00);

        // Stuck key, then 'E'
        sb_q.push_back('{1'b1, last_char});
        emitted = 1'b1;
        eighths(1'b1, 80);
        eighths(1'b0, 16);
        check("busy_after_stuck", {7'd0, BUSY}, 8'h00);
        w = '{"."};
        key_word(w);

        // Reset in the middle of the dash of 'N'
        check("sb_drained_pre_reset", 8'(sb_q.size()), 8'h00);
        eighths(1'b1, 12);
        RST = 1'b1;
        drive(1'b1, 3);
        check("mid_rst_char", CHAR, 8'h00);
        check("mid_rst_valid", {7'd0, CHAR_VALID}, 8'h00);
        check("mid_rst_err", {7'd0, ERR}, 8'h00);
        check("mid_rst_busy", {7'd0, BUSY}, 8'h00);
        drive(1'b0, 3);
        RST       = 1'b0;
        last_char = 8'h00;
        emitted   = 1'b0;
        eighths(1'b0, 8);
        w = '{"."};
        key_word(w);

        // Random words, occasionally with an undecodable letter
        for (int k = 0; k < 12; k++) begin
            w = {};
            n = int'($urandom_range(3, 1));
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(7, 0) == 0) w.push_back(bad_codes[$urandom_range(3, 0)]);
                else                           w.push_back(codes[$urandom_range(35, 0)]);
            end
            key_word(w);
        end

        eighths(1'b0, 20);
        check("sb_empty", 8'(sb_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
